// File: rtl/serial_ones_counter_pkg.sv
// Shared types and helpers for the serial ones counter and its strobe path.
// Any block that walks a frame index can size it with idx_width().
package serial_ones_counter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // A one-bit index is still needed when a frame is a single bit long.
   function automatic int unsigned idx_width(input int unsigned frame_len);
      return (frame_len > 1) ? $clog2(frame_len) : 1;
   endfunction

endpackage

// File: rtl/serial_ones_counter_tick_edge_detect.sv
// Brings a slow, asynchronous level into clock_in and turns each of its rising
// edges into a single-cycle tick.
module tick_edge_detect (
   input  logic clock_in,
   input  logic reset,
   input  logic level_in,
   output logic tick
);

   logic sync1_q, sync2_q, prev_q;

   always_ff @(posedge clock_in) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= level_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Both terms are flops, so tick is glitch-free despite being combinational.
   assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/serial_ones_counter.sv
// Counts the 1s in a FRAME_LEN-bit serial frame, sampling bit_in once per
// rising edge of the slow divider output.
module serial_ones_counter
   import serial_ones_counter_pkg::*;
#(
   parameter int unsigned FRAME_LEN = 8,
   parameter int unsigned CNT_W     = 4
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             slow_clk,
   input  logic             start,
   input  logic             bit_in,
   output logic             busy,
   output logic [CNT_W-1:0] count,
   output logic             done,
   output logic             tick
);

   localparam int unsigned          IDX_W    = idx_width(FRAME_LEN);
   localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(FRAME_LEN - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   acc_q, acc_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   count_q, count_d;

   tick_edge_detect u_tick (
      .clock_in (clock_in),
      .reset    (reset),
      .level_in (slow_clk),
      .tick     (tick)
   );

   always_ff @(posedge clock_in) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         idx_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      count_d = count_q;
      unique case (state_q)
         IDLE: begin
            // A tick coinciding with start is deliberately dropped.
            if (start) begin
               state_d = COUNT;
               acc_d   = '0;
               idx_d   = '0;
            end
         end
         COUNT: begin
            if (tick) begin
               if (idx_q == IDX_LAST) begin
                  count_d = acc_q + CNT_W'(bit_in);
                  state_d = DONE;
               end else begin
                  acc_d = acc_q + CNT_W'(bit_in);
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state_q != IDLE);
      done  = (state_q == DONE);
      count = count_q;
   end

endmodule

// File: tb/tb_serial_ones_counter.sv
// Directed bench for serial_ones_counter with FRAME_LEN=8, CNT_W=4.
module tb_serial_ones_counter;

   logic       clock_in;
   logic       reset;
   logic       slow_clk;
   logic       start;
   logic       bit_in;
   logic       busy;
   logic [3:0] count;
   logic       done;
   logic       tick;

   int tests_run = 0;
   int tests_failed = 0;
   int done_cnt = 0;
   int base;

   serial_ones_counter #(
      .FRAME_LEN (8),
      .CNT_W     (4)
   ) dut (
      .clock_in (clock_in),
      .reset    (reset),
      .slow_clk (slow_clk),
      .start    (start),
      .bit_in   (bit_in),
      .busy     (busy),
      .count    (count),
      .done     (done),
      .tick     (tick)
   );

   initial begin
      clock_in = 1'b0;
      forever #5 clock_in = ~clock_in;
   end

   always @(negedge clock_in) begin
      if (done === 1'b1) done_cnt++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clock_in);
      #1;
   endtask

   // One slow_clk period: 4 cycles high, 4 cycles low; bit_in held across it.
   task automatic send_bit(input logic b);
      bit_in   = b;
      slow_clk = 1'b1;
      cyc(4);
      slow_clk = 1'b0;
      cyc(4);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      slow_clk = 1'b1;
      start    = 1'b0;
      bit_in   = 1'b0;
      cyc(5);
      tests_run++;
      if ({busy, done, count} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_values: busy=%b done=%b count=%0d, required 0/0/0",
                  busy, done, count);
      end
      reset = 1'b0;
      cyc(6);
      tests_run++;
      if (busy !== 1'b0 || done_cnt != 0) begin
         tests_failed++;
         $display("FAIL reset_release_tick: busy=%b dones=%0d, required 0/0", busy, done_cnt);
      end
      slow_clk = 1'b0;
      cyc(4);
   endtask

   task automatic test_frame();
      logic [7:0] pat;
      pat  = 8'b1011_0010;
      base = done_cnt;
      pulse_start();
      for (int i = 7; i >= 1; i--) send_bit(pat[i]);
      bit_in   = pat[0];
      slow_clk = 1'b1;
      cyc(3);
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b1 || count !== 4'd4) begin
         tests_failed++;
         $display("FAIL frame_done: done=%b busy=%b count=%0d, required 1/1/4",
                  done, busy, count);
      end
      cyc(1);
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL frame_after_done: done=%b busy=%b, required 0/0", done, busy);
      end
      slow_clk = 1'b0;
      cyc(4);
      tests_run++;
      if (done_cnt - base != 1) begin
         tests_failed++;
         $display("FAIL frame_done_count: got %0d, required 1", done_cnt - base);
      end
   endtask

   task automatic test_ones_then_zeros();
      base = done_cnt;
      pulse_start();
      for (int i = 0; i < 8; i++) send_bit(1'b1);
      tests_run++;
      if (count !== 4'd8) begin
         tests_failed++;
         $display("FAIL all_ones: count=%0d, required 8", count);
      end
      pulse_start();
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      tests_run++;
      if (count !== 4'd8 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL count_hold: count=%0d busy=%b, required 8/1", count, busy);
      end
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      tests_run++;
      if (count !== 4'd0 || done_cnt - base != 2) begin
         tests_failed++;
         $display("FAIL all_zeros: count=%0d dones=%0d, required 0/2", count, done_cnt - base);
      end
   endtask

   task automatic test_start_on_tick();
      base     = done_cnt;
      bit_in   = 1'b1;
      slow_clk = 1'b1;
      cyc(2);
      start = 1'b1;
      tests_run++;
      if (tick !== 1'b1) begin
         tests_failed++;
         $display("FAIL tick_timing: tick=%b, required 1", tick);
      end
      cyc(1);
      start = 1'b0;
      cyc(1);
      slow_clk = 1'b0;
      cyc(4);
      for (int i = 0; i < 7; i++) send_bit(1'b1);
      tests_run++;
      if (done_cnt != base || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL start_tick_not_counted: dones=%0d busy=%b, required 0/1",
                  done_cnt - base, busy);
      end
      send_bit(1'b1);
      tests_run++;
      if (done_cnt - base != 1 || count !== 4'd8) begin
         tests_failed++;
         $display("FAIL start_tick_frame: dones=%0d count=%0d, required 1/8",
                  done_cnt - base, count);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] pat;
      pat  = 8'b1110_0000;
      base = done_cnt;
      pulse_start();
      for (int i = 7; i >= 1; i--) begin
         send_bit(pat[i]);
         pulse_start();
      end
      bit_in   = pat[0];
      slow_clk = 1'b1;
      cyc(3);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      slow_clk = 1'b0;
      cyc(4);
      tests_run++;
      if (busy !== 1'b0 || count !== 4'd3 || done_cnt - base != 1) begin
         tests_failed++;
         $display("FAIL no_restart: busy=%b count=%0d dones=%0d, required 0/3/1",
                  busy, count, done_cnt - base);
      end
      for (int i = 0; i < 8; i++) send_bit(1'b1);
      tests_run++;
      if (busy !== 1'b0 || count !== 4'd3 || done_cnt - base != 1) begin
         tests_failed++;
         $display("FAIL idle_ignores_ticks: busy=%b count=%0d dones=%0d, required 0/3/1",
                  busy, count, done_cnt - base);
      end
   endtask

   task automatic test_reset_mid_frame();
      base = done_cnt;
      pulse_start();
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      cyc(2);
      tests_run++;
      if (busy !== 1'b0 || count !== 4'd0 || done_cnt != base) begin
         tests_failed++;
         $display("FAIL reset_mid_frame: busy=%b count=%0d dones=%0d, required 0/0/0",
                  busy, count, done_cnt - base);
      end
      pulse_start();
      for (int i = 0; i < 8; i++) send_bit(1'b1);
      tests_run++;
      if (count !== 4'd8 || done_cnt - base != 1) begin
         tests_failed++;
         $display("FAIL frame_after_reset: count=%0d dones=%0d, required 8/1",
                  count, done_cnt - base);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_ones_then_zeros();
      test_start_on_tick();
      test_back_to_back();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/serial_ones_counter.md
Name: serial_ones_counter

Overview:
- Downstream consumer of the clock divider's slow `clock_out` square wave.
- Treats that slow wave as a sampling strobe rather than a clock: synchronises it into the fast `clock_in` domain and edge-detects it into one-cycle ticks.
- On each tick, shifts one serial bit and counts the 1s in a frame of FRAME_LEN bits, then reports the count with a done pulse.
- Gives the bit-counter lab a visible, human-speed sampling rate with single-clock RTL.

Parameters:
- FRAME_LEN, 8, number of serial bits per frame; must be ≥2.
- CNT_W, 4, width of the count output; must satisfy 2^CNT_W > FRAME_LEN.

Ports:
- clock_in  input  1  fast board clock; the only clock in the block.
- reset  input  1  synchronous, active-high reset.
- slow_clk  input  1  divided clock from the divider; asynchronous-like level, treated as data.
- start  input  1  request to begin a frame; honoured only in IDLE.
- bit_in  input  1  serial data bit, sampled on ticks.
- busy  output  1  high in COUNT and DONE.
- count  output  CNT_W  number of 1s in the last completed frame; held until the next frame completes.
- done  output  1  one-cycle pulse when count updates.
- tick  output  1  debug: the one-cycle edge strobe.

Behaviour:
- Single clock: clock_in. Reset is synchronous and active-high; everything is updated on posedge clock_in.
- Reset values: state=IDLE; sync1/sync2/prev=0; acc=0; idx=0; count=0; done=0; busy=0.
- Strobe path (sub-module):
  - sync1 <= slow_clk; sync2 <= sync1; prev <= sync2.
  - tick = sync2 & ~prev (combinational, registered inputs).
  - A slow_clk rise reaches tick 2 clock_in edges later. tick is high for exactly one cycle per slow_clk rising edge.
- IDLE:
  - busy=0, done=0. Ticks are ignored.
  - start=1 → COUNT with acc=0, idx=0.
- COUNT (busy=1):
  - Only tick cycles act. On tick, acc <= acc + bit_in and idx <= idx + 1.
  - On the tick where idx == FRAME_LEN-1:
    - count <= acc + bit_in;
    - done <= 1;
    - state → DONE.
  - start is ignored.
- DONE (busy=1, done=1):
  - Lasts exactly one cycle, then → IDLE.
  - start in this cycle is ignored; a new frame needs start in a later IDLE cycle.
  - A tick in this cycle is ignored.
- Arithmetic:
  - acc is CNT_W bits and never wraps, given the CNT_W constraint.
  - idx is $clog2(FRAME_LEN) bits, max value FRAME_LEN-1.
- Boundaries:
  - All-zero frame → count=0.
  - All-one frame → count=FRAME_LEN.
  - start and tick in the same IDLE cycle: the transition happens and that tick is NOT counted. The first counted bit comes from the next tick.
  - slow_clk high at reset release: a tick appears 2 cycles after reset drops, but the FSM is in IDLE, so it is ignored.
  - Reset mid-frame: the frame is abandoned and count returns to 0, with no done pulse.
  - slow_clk glitch-free, with high and low phases each ≥3 clock_in cycles: guaranteed one tick per period. Narrower pulses may be missed.
- Latency from the final slow_clk rise to done high: 3 clock_in edges.

Decomposition:
- Shared package: state encoding localparams IDLE=2'd0, COUNT=2'd1, DONE=2'd2, and a helper constant for idx width.
- One natural sub-module: tick_edge_detect, covering the 2-flop synchroniser plus rising-edge detector.
  - Ports: clock_in, reset, level_in, tick.
  - Reusable by other labs that consume the divider's output.

Test Plan:
- Reset held 5 cycles with slow_clk=1 → count=0, busy=0, done=0; no state change after release.
- FRAME_LEN=8, start pulse, bit_in pattern 1,0,1,1,0,0,1,0 across 8 slow_clk rises → one done pulse, count=4, busy falls the cycle after done.
- Frame of all 1s, then a second frame of all 0s → count=8 after the first done, holds 8 until the second done, then becomes 0.
- start asserted the same cycle as a tick, then 8 more ticks with bit_in=1 → the first tick is not counted; done after the 8th following tick, count=8.
- start pulsed repeatedly during COUNT and in the DONE cycle → no restart; exactly one done per accepted frame.
- reset asserted after 5 ticks of an all-1 frame → count=0, state IDLE, no done. A fresh start plus 8 ticks of 1s → count=8.
